serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It time-shares one instance of the team's `full_adder` cell to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. The block owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. It sits between a requester that issues add commands and the single-bit `full_adder` datapath, and replaces a WIDTH-bit ripple adder where area matters more than latency.

---
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell adds two WIDTH-bit operands plus carry-in, LSB first.
// Optional signed-overflow output `ovf` is built when SERIAL_ADDER_OVF_EN is defined.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshake: start is a request taken only in IDLE (busy low means ready);
  // done is a one-cycle valid strobe for sum/c_out, which then hold until the next accept.
  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rs_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (ra[0]),
    .b  (rb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit i has reached position i.
  assign rs_next = WIDTH'({fa_s, rs} >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            carry <= c_in;
            cnt   <= '0;
            rs    <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          rs    <= rs_next;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Visible outputs change only here, so partial sums never leak out.
            sum   <= rs_next;
            c_out <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ fa_co;
`endif
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 instance for directed/random adds,
// WIDTH=2 instance for an exhaustive back-to-back sweep. Checks ovf when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
  logic         ovf2;
`endif

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       c2 = 1'b0;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       co2;

  int vectors = 0;
  int miscompares = 0;

  // {ovf, c_out, sum}
  logic [W+1:0] exp_q[$];
  // {c_out, sum}
  logic [2:0]   exp2_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .c_in  (c2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .c_out (co2)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf2)
`endif
  );

  // ---------------- driver tasks ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                          input logic tc);
    logic [W:0] s;
    logic       v;
    s = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    v = (ta[W-1] == tb[W-1]) && (s[W-1] != ta[W-1]);
    return {v, s};
  endfunction

  // Accepting edge is the second posedge; returns 1 ns after it with operands scrambled.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    exp_q.push_back(model(ta, tb, tc));
    @(posedge clk); #1;
    a = ta; b = tb; c_in = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1; a = 8'h11; b = 8'h22;
    start2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, c_out, sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b c_out=%b sum=%h, want all zero",
               busy, done, c_out, sum);
    end
    vectors++;
    if ({busy2, done2, co2, sum2} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_w2: got busy=%b done=%b c_out=%b sum=%h, want all zero",
               busy2, done2, co2, sum2);
    end
`ifdef SERIAL_ADDER_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_latency();
    logic [W+1:0] e;
    issue(8'h00, 8'h00, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_busy_e0: got busy=%b want 1", busy);
    end
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      vectors++;
      if (done !== (k == W) || busy !== (k <= W)) begin
        miscompares++;
        $display("FAIL latency_k%0d: got done=%b busy=%b want done=%b busy=%b",
                 k, done, busy, (k == W), (k <= W));
      end
      if (k == W) begin
        e = exp_q.pop_front();
        vectors++;
        if ({c_out, sum} !== e[W:0]) begin
          miscompares++;
          $display("FAIL latency_result: got %h want %h", {c_out, sum}, e[W:0]);
        end
      end
    end
  endtask

  task automatic test_vectors();
    logic [2*W:0] tbl [0:8];
    logic [W+1:0] e;
    int           n;
    bit           found;
    tbl[0] = {8'hFF, 8'h01, 1'b0};
    tbl[1] = {8'hA5, 8'h5A, 1'b1};
    tbl[2] = {8'h3C, 8'h0F, 1'b1};
    for (int i = 3; i < 9; i++) tbl[i] = (2*W+1)'($urandom);
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i][2*W:W+1], tbl[i][W:1], tbl[i][0]);
      found = 1'b0;
      n = 0;
      for (int k = 0; k < 3 * W && !found; k++) begin
        @(negedge clk);
        n = k;
        if (done === 1'b1) found = 1'b1;
      end
      e = exp_q.pop_front();
      vectors++;
      if (!found || n != W) begin
        miscompares++;
        $display("FAIL vec%0d_latency: got found=%0d cycles=%0d want found=1 cycles=%0d",
                 i, found, n, W);
      end
      vectors++;
      if ({c_out, sum} !== e[W:0]) begin
        miscompares++;
        $display("FAIL vec%0d_result: got %h want %h", i, {c_out, sum}, e[W:0]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      vectors++;
      if (ovf !== e[W+1]) begin
        miscompares++;
        $display("FAIL vec%0d_ovf: got %b want %b", i, ovf, e[W+1]);
      end
`endif
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL vec%0d_done_width: got done=%b want 0", i, done);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W+1:0] e;
    int           n;
    bit           found;
    issue(8'h3C, 8'h0F, 1'b1);
    found = 1'b0;
    n = 0;
    for (int k = 0; k < 3 * W && !found; k++) begin
      @(negedge clk);
      n = k;
      if (k == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
      end
      if (k == 3) start = 1'b0;
      if (done === 1'b1) found = 1'b1;
    end
    e = exp_q.pop_front();
    vectors++;
    if (!found || n != W || {c_out, sum} !== e[W:0]) begin
      miscompares++;
      $display("FAIL ignore_run: got found=%0d cycles=%0d result=%h want cycles=%0d result=%h",
               found, n, {c_out, sum}, W, e[W:0]);
    end
    // Now in DONE: a start here must not be taken.
    start = 1'b1; a = 8'h01; b = 8'h01; c_in = 1'b0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || {c_out, sum} !== e[W:0]) begin
        miscompares++;
        $display("FAIL ignore_done_hold%0d: got done=%b busy=%b result=%h want 0 0 %h",
                 k, done, busy, {c_out, sum}, e[W:0]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W+1:0] e;
    int           n;
    bit           found;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, c_out, sum} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got busy=%b done=%b c_out=%b sum=%h want all zero",
               busy, done, c_out, sum);
    end
    reset = 1'b0;
    a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h12, 8'h34, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_restart_busy: got %b want 1", busy);
    end
    found = 1'b0;
    n = 0;
    for (int k = 0; k < 3 * W && !found; k++) begin
      @(negedge clk);
      n = k;
      if (done === 1'b1) found = 1'b1;
    end
    e = exp_q.pop_front();
    vectors++;
    if (!found || n != W || {c_out, sum} !== e[W:0]) begin
      miscompares++;
      $display("FAIL midrun_fresh_add: got found=%0d cycles=%0d result=%h want cycles=%0d result=%h",
               found, n, {c_out, sum}, W, e[W:0]);
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [2*W:0] tbl [0:2];
    logic [W+1:0] want [0:2];
    logic [W+1:0] e;
    bit           found;
    tbl[0] = {8'h7F, 8'h01, 1'b0}; want[0] = {1'b1, 1'b0, 8'h80};
    tbl[1] = {8'h80, 8'h80, 1'b0}; want[1] = {1'b1, 1'b1, 8'h00};
    tbl[2] = {8'hFF, 8'h01, 1'b0}; want[2] = {1'b0, 1'b1, 8'h00};
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i][2*W:W+1], tbl[i][W:1], tbl[i][0]);
      e = exp_q.pop_front();
      found = 1'b0;
      for (int k = 0; k < 3 * W && !found; k++) begin
        @(negedge clk);
        if (done === 1'b1) found = 1'b1;
      end
      vectors++;
      if (!found || {ovf, c_out, sum} !== want[i]) begin
        miscompares++;
        $display("FAIL ovf%0d: got found=%0d {ovf,c_out,sum}=%h want %h",
                 i, found, {ovf, c_out, sum}, want[i]);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          @(posedge clk); #1;
          a2 = 2'(i >> 3); b2 = 2'(i >> 1); c2 = 1'(i);
          exp2_q.push_back(3'(i >> 3) + 3'((i >> 1) & 3) + 3'(i & 1));
          start2 = 1'b1;
          @(posedge clk); #1;
          start2 = 1'b0;
          repeat (2) @(posedge clk);
        end
      end
      begin
        int         seen;
        logic       prev;
        logic [2:0] e;
        seen = 0;
        prev = 1'b0;
        for (int n = 0; n < 32 * 4 + 16 && seen < 32; n++) begin
          @(negedge clk);
          if (prev) begin
            vectors++;
            if (done2 !== 1'b0) begin
              miscompares++;
              $display("FAIL sweep_done_width: done high two cycles at done #%0d", seen);
            end
          end
          if (done2 === 1'b1 && !prev) begin
            e = (exp2_q.size() > 0) ? exp2_q.pop_front() : 3'bxxx;
            vectors++;
            if ({co2, sum2} !== e) begin
              miscompares++;
              $display("FAIL sweep_result%0d: got %b want %b", seen, {co2, sum2}, e);
            end
            seen++;
          end
          prev = done2;
        end
        vectors++;
        if (seen != 32) begin
          miscompares++;
          $display("FAIL sweep_count: got %0d dones want 32", seen);
        end
      end
    join
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_ignore_start();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
